// File: rtl/ram_rr_arbiter.sv
// Two-port round-robin arbiter in front of one single-port RAM (registered read address).
// Supports a sticky ownership lock for bursts and returns read data per port after two cycles.
module ram_rr_arbiter #(
  parameter int dataW = 8,
  parameter int addrW = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [addrW-1:0] addr0,
  input  logic [addrW-1:0] addr1,
  input  logic [dataW-1:0] wdata0,
  input  logic [dataW-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [dataW-1:0] rdata0,
  output logic [dataW-1:0] rdata1,
  output logic [addrW-1:0] ram_addr,
  output logic [dataW-1:0] ram_din,
  output logic             ram_we,
  input  logic [dataW-1:0] ram_q
);

  // state | meaning
  // IDLE  | no owner; round-robin between requesters using r_last
  // OWN0  | port 0 holds the lock; only port 0 can be granted
  // OWN1  | port 1 holds the lock; only port 1 can be granted
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any_gnt;
  logic             w_rd_gnt;
  logic             r_s1_valid;
  logic             r_s1_port;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic [dataW-1:0] r_rdata0;
  logic [dataW-1:0] r_rdata1;

  // Grant depends only on state, last and req; forced low while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (resetN) begin
      case (r_state)
        IDLE: begin
          if (req0 && req1) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
        end
        OWN0:    w_gnt0 = req0;
        OWN1:    w_gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt0 && lock0) begin
      w_state_nxt = OWN0;
    end else if (w_gnt1 && lock1) begin
      w_state_nxt = OWN1;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_rd_gnt  = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign ram_addr = w_gnt1 ? addr1 : addr0;
  assign ram_din  = w_gnt1 ? wdata1 : wdata0;
  assign ram_we   = (w_gnt0 & we0) | (w_gnt1 & we1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_any_gnt) begin
        r_last <= w_gnt1;
      end
    end
  end

  // Stage 1 tags the read launched this edge; stage 2 captures RAM output one cycle later.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_valid <= 1'b0;
      r_s1_port  <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_s1_valid <= w_rd_gnt;
      r_s1_port  <= w_gnt1;
      r_rvalid0  <= r_s1_valid & ~r_s1_port;
      r_rvalid1  <= r_s1_valid & r_s1_port;
      if (r_s1_valid && !r_s1_port) begin
        r_rdata0 <= ram_q;
      end
      if (r_s1_valid && r_s1_port) begin
        r_rdata1 <= ram_q;
      end
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: models the single-port RAM with a registered read address,
// checks grants inline per scenario and read returns through a scoreboard queue.
module tb_ram_rr_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         due;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  logic [7:0] exp_mem [32];
  logic       exp_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_rr_arbiter #(.dataW(8), .addrW(5)) dut (
    .clk(clk), .resetN(resetN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  // genericRAM: write and address register update on the same edge
  logic [7:0] mem [32];
  logic [4:0] mem_addr_r = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    mem_addr_r <= ram_addr;
  end
  assign ram_q = mem[mem_addr_r];

  always @(negedge clk) begin
    if (resetN) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL rvalid_missing port=%0d due_cycle=%0d now=%0d", sb[0].port, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (rvalid0 || rvalid1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rvalid_unexpected rvalid0=%0b rvalid1=%0b expected none", rvalid0, rvalid1);
        end else begin
          mon_e = sb.pop_front();
          if ({rvalid1, rvalid0} !== (mon_e.port ? 2'b10 : 2'b01) ||
              (mon_e.port ? rdata1 : rdata0) !== mon_e.data || mon_e.due != cyc) begin
            bad++;
            $display("FAIL rdata_return got rv1/rv0=%0b%0b rdata0=%h rdata1=%h cyc=%0d want port=%0d data=%h cyc=%0d",
                     rvalid1, rvalid0, rdata0, rdata1, cyc, mon_e.port, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [4:0] a0,
                       input logic [7:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [4:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 5'd0, 8'd0, 0, 0, 0, 5'd0, 8'd0);
  endtask

  // Records the effect of a grant the bench expects for port p.
  task automatic note(input int p);
    sb_t e;
    if (p == 0) begin
      if (we0) exp_mem[addr0] = wdata0;
      else begin e.port = 1'b0; e.data = exp_mem[addr0]; e.due = cyc + 2; sb.push_back(e); end
    end else begin
      if (we1) exp_mem[addr1] = wdata1;
      else begin e.port = 1'b1; e.data = exp_mem[addr1]; e.due = cyc + 2; sb.push_back(e); end
    end
    exp_last = (p != 0);
  endtask

  function automatic logic [7:0] wd(input int a);
    return 8'(a * 7 + 17);
  endfunction

  task automatic test_reset;
    resetN = 1'b0;
    req0 = 1; we0 = 1; lock0 = 0; addr0 = 5'd4; wdata0 = 8'h77;
    req1 = 1; we1 = 1; lock1 = 0; addr1 = 5'd6; wdata1 = 8'h66;
    #1;
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 ||
        rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs gnt=%0b%0b we=%0b rv=%0b%0b rdata0=%h rdata1=%h want all 0",
               gnt0, gnt1, ram_we, rvalid0, rvalid1, rdata0, rdata1);
    end
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    exp_last = 1'b1;
  endtask

  task automatic test_write_read;
    drive(1, 1, 0, 5'd5, 8'hA5, 0, 0, 0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 5'd5 || ram_din !== 8'hA5) begin
      bad++;
      $display("FAIL wr0_grant gnt=%0b%0b we=%0b addr=%0d din=%h want 1,0,1,5,a5",
               gnt0, gnt1, ram_we, ram_addr, ram_din);
    end
    note(0);
    drive(0, 0, 0, 5'd0, 8'd0, 1, 0, 0, 5'd5, 8'd0);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd5) begin
      bad++;
      $display("FAIL rd1_grant gnt=%0b%0b we=%0b addr=%0d want 0,1,0,5", gnt0, gnt1, ram_we, ram_addr);
    end
    note(1);
    idle(3);
    total++;
    if (rdata1 !== 8'hA5) begin
      bad++;
      $display("FAIL rd1_hold rdata1=%h want a5", rdata1);
    end
  endtask

  task automatic test_alternate;
    drive(1, 1, 0, 5'd1, 8'h11, 0, 0, 0, 5'd0, 8'd0);
    note(0);
    drive(0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 5'd2, 8'h22);
    note(1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 5'd1, 8'd0, 1, 0, 0, 5'd2, 8'd0);
      total++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL alt_grant step=%0d gnt0=%0b gnt1=%0b want %0b/%0b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1);
      end
      note(i % 2);
    end
    idle(3);
  endtask

  task automatic test_lock;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 5'd1, 8'd0, 1, 0, 0, 5'd2, 8'd0);
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        bad++;
        $display("FAIL lock_grant step=%0d gnt0=%0b gnt1=%0b want 1/0", i, gnt0, gnt1);
      end
      note(0);
    end
    drive(0, 0, 0, 5'd0, 8'd0, 1, 0, 0, 5'd2, 8'd0);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL lock_release_gap gnt0=%0b gnt1=%0b we=%0b want 0/0/0", gnt0, gnt1, ram_we);
    end
    drive(0, 0, 0, 5'd0, 8'd0, 1, 0, 0, 5'd2, 8'd0);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL lock_after gnt0=%0b gnt1=%0b want 0/1", gnt0, gnt1);
    end
    note(1);
    idle(3);
  endtask

  task automatic test_raw;
    drive(1, 1, 0, 5'd3, 8'h3C, 0, 0, 0, 5'd0, 8'd0);
    note(0);
    drive(1, 0, 0, 5'd3, 8'd0, 0, 0, 0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL raw0_grant gnt0=%0b we=%0b want 1/0", gnt0, ram_we);
    end
    note(0);
    drive(1, 1, 0, 5'd3, 8'hC3, 0, 0, 0, 5'd0, 8'd0);
    note(0);
    drive(0, 0, 0, 5'd0, 8'd0, 1, 0, 0, 5'd3, 8'd0);
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL raw1_grant gnt0=%0b gnt1=%0b want 0/1", gnt0, gnt1);
    end
    note(1);
    idle(3);
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 0, 5'd1, 8'd0, 0, 0, 0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_grant gnt0=%0b want 1", gnt0);
    end
    @(posedge clk);
    #1;
    resetN = 1'b0;
    req0 = 1; we0 = 0; addr0 = 5'd1; req1 = 1; we1 = 0; addr1 = 5'd2;
    sb.delete();
    #1;
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 ||
        rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_outputs gnt=%0b%0b we=%0b rv=%0b%0b rdata0=%h rdata1=%h want all 0",
               gnt0, gnt1, ram_we, rvalid0, rvalid1, rdata0, rdata1);
    end
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    exp_last = 1'b1;
    #1;
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_first_tie gnt0=%0b gnt1=%0b want 1/0", gnt0, gnt1);
    end
    note(0);
    idle(4);
  endtask

  task automatic test_write_all;
    int   n0 = 0;
    int   n1 = 0;
    int   cycles = 0;
    logic want1;
    while ((n0 < 16 || n1 < 16) && cycles < 100) begin
      drive(n0 < 16, 1, 0, 5'(2 * n0), wd(2 * n0), n1 < 16, 1, 0, 5'(2 * n1 + 1), wd(2 * n1 + 1));
      if (n0 < 16 && n1 < 16) want1 = ~exp_last;
      else want1 = (n1 < 16);
      total++;
      if (gnt0 !== ~want1 || gnt1 !== want1 || ram_we !== 1'b1) begin
        bad++;
        $display("FAIL wall_grant n0=%0d n1=%0d gnt0=%0b gnt1=%0b we=%0b want gnt1=%0b we=1",
                 n0, n1, gnt0, gnt1, ram_we, want1);
      end
      if (want1) begin note(1); n1++; end
      else begin note(0); n0++; end
      cycles++;
    end
    total++;
    if (cycles >= 100) begin
      bad++;
      $display("FAIL wall_timeout cycles=%0d want <100", cycles);
    end
    idle(2);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 5'(i), 8'd0, 0, 0, 0, 5'd0, 8'd0);
      total++;
      if (gnt0 !== 1'b1) begin
        bad++;
        $display("FAIL wall_read_grant addr=%0d gnt0=%0b want 1", i, gnt0);
      end
      note(0);
    end
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_raw();
    test_reset_mid();
    test_write_all();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
# ram_rr_arbiter

Two-requester arbiter that shares one single-port `genericRAM` instance (registered read address, one access per clock) between two clients. It applies round-robin arbitration with an optional lock for back-to-back bursts. It drives the RAM address, data and write-enable from the winning requester and routes read data back with a per-port valid strobe. It sits between client FSMs (e.g. a register-file loader and a display scanner) and the RAM.

## Interface
- `dataW`, default 8, RAM word width.
- `addrW`, default 5, RAM address width (depth 2**addrW).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetN`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  access request, held until granted.
- `we0`, `we1`  in  1  1 = write, 0 = read; valid with req.
- `lock0`, `lock1`  in  1  keep ownership after this grant.
- `addr0`, `addr1`  in  addrW  access address.
- `wdata0`, `wdata1`  in  dataW  write data.
- `gnt0`, `gnt1`  out  1  combinational; request accepted at the coming edge.
- `rvalid0`, `rvalid1`  out  1  registered; one-cycle read-data strobe.
- `rdata0`, `rdata1`  out  dataW  registered read data; holds until the next read completes on that port.
- `ram_addr`  out  addrW  to RAM `addr`.
- `ram_din`  out  dataW  to RAM `dataIN`.
- `ram_we`  out  1  to RAM `enWR`.
- `ram_q`  in  dataW  from RAM `Q`.

## Operation
- State machine with three states: IDLE, OWN0, OWN1. A `last` pointer records the most recently granted port.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the port ≠ `last`.
  - None high: no grant.
- OWNn:
  - reqn high: grant n; the other port is never granted.
  - reqn low: no grant this cycle; go to IDLE.
- On any grant to port n: `last` ← n.
  - lockn = 1: next state OWNn.
  - lockn = 0: next state IDLE.
- At most one gnt is high per cycle. gnt is a combinational function of state, `last` and req only; it never depends on we, addr or lock.
- RAM mux: when gntn = 1, `ram_addr`/`ram_din` = addrn/wdatan and `ram_we` = wen. With no grant, `ram_we` = 0 and `ram_addr`/`ram_din` hold port 0 values (don't-care).
- Read tracking: a 2-stage pipeline of {valid, port id}. Stage 1 is loaded at the grant edge for reads only. At the next edge, stage 2 captures `ram_q` into rdata[port] and sets rvalid[port] for one cycle.
- Writes produce no rvalid.
- Read-after-write to the same address in the next cycle returns the new data, because the RAM updates storage and the registered address on the same edge.
- One access per cycle with full throughput. Reads from alternating ports may overlap in the pipeline, and each returns on its own port in grant order.

## Timing
- Read latency: grant in cycle k → rvalid/rdata valid in cycle k+2.
- Write: committed at the end of the grant cycle k.
- Requester rule: keep req, we, lock, addr and wdata stable until gnt is seen high. Deassert req (or present the next request) in the cycle after the grant. A request held high after gnt is treated as a new request.
- Reset (resetN = 0, immediate):
  - state = IDLE, `last` = 1, so port 0 wins the first tie.
  - Pipeline cleared; rvalid0/1 = 0; rdata0/1 = 0.
  - gnt0/1 and `ram_we` = 0 while resetN is low.
- Reset mid-operation: in-flight reads are dropped with no rvalid. A write is committed only if its grant edge completed before resetN fell.
- Release of resetN takes effect at the next rising edge. The first grant is possible in that cycle.
- Simultaneous requests in IDLE strictly alternate. No port is starved for more than one grant unless the other port holds lock.
- Lock with req low is ignored. A lock held by the owner indefinitely starves the other port by design.

## Test plan
- Reset then port-0 write: addr0=5, wdata0=8'hA5, we0=1 → gnt0 in the request cycle. Then a port-1 read of addr 5 → gnt1; rvalid1 two cycles later with rdata1=8'hA5; rvalid0 stays 0.
- Both ports request reads every cycle (addr0=1, addr1=2) → gnt alternates 0,1,0,1 starting with 0; rvalid0/rvalid1 alternate with a 2-cycle lag and return the correct data per port.
- Port 0 holds lock0=1 for 4 reads while req1 is high → gnt0 for 4 consecutive cycles and gnt1=0. When req0 drops: one idle cycle, then gnt1.
- Write addr 3 = 8'h3C, then read addr 3 in the immediately following cycle → rdata=8'h3C (no stale data).
- Assert resetN=0 one cycle after a read grant → no rvalid. All outputs read 0 immediately, and the next tie after reset goes to port 0.
- Write-only traffic on both ports with no reads → rvalid0/1 never assert; every one of the 32 addresses reads back its written value.
